spi_responder: RTL and testbench
================================

Name: spi_responder

Overview:
- SPI slave (mode 0, MSB first) that terminates the frames generated by the core's SPI masters (sclk/mosi/sen and sclk_chirp/mosi_chirp).
- Used for on-board loopback and bring-up of the chirp SPI path, and as the daughterboard-side model in system sims.
- Oversamples the SPI pins in the `clk` domain, captures one WIDTH-bit word per frame and shifts a preloaded response word out on `miso`.

Parameters:
- WIDTH, 24: bits per frame; must be between 8 and 32.
- SYNC_STAGES, 2: synchronizer flops on each SPI input; must be at least 2.

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- sclk, input, 1: SPI clock from the master; asynchronous to `clk`.
- mosi, input, 1: SPI data from the master.
- sen, input, 1: active-low frame enable.
- miso, output, 1: SPI data to the master.
- tx_data, input, WIDTH: response word, sampled at frame start.
- tx_ack, output, 1: 1-cycle pulse when `tx_data` has been latched.
- rx_data, output, WIDTH: last correctly sized received word.
- rx_valid, output, 1: 1-cycle pulse when `rx_data` updates.
- rx_error, output, 1: 1-cycle pulse when a frame ends with the wrong bit count.
- busy, output, 1: high while a frame is active.

Behaviour:
- Reset values:
  - miso=0, tx_ack=0, rx_data=0, rx_valid=0, rx_error=0, busy=0.
  - Synchronizers reset to sen=1, sclk=0, mosi=0.
  - State is IDLE_UNARMED.
- Synchronization:
  - Each input passes through SYNC_STAGES flops, then one history flop for edge detection.
  - An edge is acted on SYNC_STAGES+1 clk cycles after the pin changes (3 cycles at default).
  - Requirement on the master: sclk high time, sclk low time, and sen-fall-to-first-sclk-rise are each at least SYNC_STAGES+2 clk periods.
- States:
  - IDLE_UNARMED: waiting for synchronized sen=1. Goes to IDLE on the first cycle sen=1. This prevents a frame that was already in progress at reset release from being captured as a partial word.
  - IDLE: busy=0, miso=0, bit_cnt=0. A sen falling edge causes, in that same cycle:
    - shift_out <= tx_data;
    - tx_ack pulses;
    - bit_cnt <= 0;
    - transition to ACTIVE.
  - ACTIVE: busy=1.
    - miso is driven from shift_out[WIDTH-1] combinationally from a register, so the first bit is valid one clk after sen fall is detected.
    - Synchronized sclk rising edge: shift_in <= {shift_in[WIDTH-2:0], mosi_sync}. bit_cnt increments and saturates at WIDTH+1.
    - Synchronized sclk falling edge: shift_out <= shift_out << 1, zero fill.
    - Synchronized sen rising edge: go to IDLE.
      - If bit_cnt==WIDTH: rx_data <= shift_in and rx_valid pulses in the cycle after the edge is detected.
      - Otherwise rx_error pulses in that cycle and rx_data holds its previous value.
      - miso returns to 0.
- Simultaneous and out-of-frame events:
  - sclk edges while sen=1 are ignored.
  - sclk edges detected in the same cycle as the sen falling edge are ignored.
  - An sclk rising edge detected in the same cycle as the sen rising edge is ignored; the frame ends with the count as it stood.
- Overflow: more than WIDTH rising edges saturates bit_cnt at WIDTH+1, and the frame ends with rx_error. shift_in still holds the last WIDTH bits but is not published.
- tx_data changes after tx_ack have no effect until the next frame.
- rx_valid and rx_error are never high in the same cycle.
- Asserting rst mid-frame aborts immediately with no rx_valid or rx_error pulse. The block returns to IDLE_UNARMED; any remainder of that frame is discarded.

Test Plan:
- Single frame:
  - Stimulus: WIDTH=24, tx_data=24'hA5C3F0; master sends 24'h123456 with sclk = clk/16.
  - Required: rx_data=24'h123456 with exactly one rx_valid pulse; bits sampled on miso at the sclk rising edges read 24'hA5C3F0; one tx_ack pulse at frame start.
- Short frame: master sends 20 bits, then raises sen.
  - Required: one rx_error pulse, no rx_valid, rx_data unchanged from the previous frame, busy=0 afterward.
- Long frame: master sends 26 bits.
  - Required: rx_error pulse and rx_data unchanged.
  - A following correct 24-bit frame of 24'hFFFFFF produces rx_valid with rx_data=24'hFFFFFF.
- Back-to-back frames: two frames separated by sen high for 4 clk cycles, tx_data changed from 24'h000001 to 24'h800000 between them.
  - Required: two rx_valid pulses with correct data, two tx_ack pulses; second frame miso reads 24'h800000.
- Reset mid-frame: assert rst after 10 bits with sen held low, release it, then continue 14 more bits and raise sen.
  - Required: no rx_valid or rx_error for that frame; busy stays 0; the next full frame is received correctly.
- Idle noise: toggle sclk and mosi 50 times with sen=1.
  - Required: no pulses on any output, miso=0, busy=0.

Source files
------------

// File: rtl/spi_responder.sv
// SPI mode-0 slave, MSB first: oversamples the SPI pins in the clk domain,
// captures one WIDTH-bit word per frame and shifts a preloaded word out on miso.
module spi_responder #(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             sen,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ack,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_error,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE_UNARMED, IDLE, ACTIVE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, sen_sync;
  logic                   sclk_d, sen_d;
  logic [SYNC_STAGES:0]   arm_pipe;
  logic [WIDTH-1:0]       shift_in, shift_out;
  logic [CW-1:0]          bit_cnt;

  logic sclk_s, mosi_s, sen_s;
  logic sclk_rise, sclk_fall, sen_rise, sen_fall, armed;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sen_s     = sen_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign sen_rise  = sen_s & ~sen_d;
  assign sen_fall  = ~sen_s & sen_d;
  // The sen chain resets to 1, so the real pin level is only trusted once it
  // has propagated through the whole chain; otherwise a frame in progress at
  // reset release would show up as a fresh sen fall.
  assign armed     = arm_pipe[SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      sen_sync  <= '1;
      sclk_d    <= 1'b0;
      sen_d     <= 1'b1;
      arm_pipe  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sen_sync  <= {sen_sync[SYNC_STAGES-2:0], sen};
      sclk_d    <= sclk_s;
      sen_d     <= sen_s;
      arm_pipe  <= {arm_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE_UNARMED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_UNARMED: if (armed && sen_s) state_nxt = IDLE;
      IDLE:         if (sen_fall)       state_nxt = ACTIVE;
      ACTIVE:       if (sen_rise)       state_nxt = IDLE;
      default:                          state_nxt = IDLE_UNARMED;
    endcase
  end

  always_comb begin
    busy = (state == ACTIVE);
    miso = busy & shift_out[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_in  <= '0;
      shift_out <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
      tx_ack    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      tx_ack   <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (sen_fall) begin
            shift_out <= tx_data;
            tx_ack    <= 1'b1;
          end
        end
        ACTIVE: begin
          // Frame end wins over a coincident sclk rise: the count stands.
          if (sen_rise) begin
            if (bit_cnt == CW'(WIDTH)) begin
              rx_data  <= shift_in;
              rx_valid <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              shift_in <= {shift_in[WIDTH-2:0], mosi_s};
              if (bit_cnt != CW'(WIDTH + 1)) bit_cnt <= bit_cnt + CW'(1);
            end
            if (sclk_fall) shift_out <= {shift_out[WIDTH-2:0], 1'b0};
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_responder.sv
// Directed + randomized bench for spi_responder: a bit-banged SPI master and a
// word-level reference model of what each frame should publish.
module tb_spi_responder;
  localparam int W = 24;

  logic          clk = 1'b0, rst = 1'b1;
  logic          sclk = 1'b0, mosi = 1'b0, sen = 1'b1;
  logic          miso, tx_ack, rx_valid, rx_error, busy;
  logic [W-1:0]  tx_data = '0, rx_data;

  spi_responder #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .sen(sen), .miso(miso),
    .tx_data(tx_data), .tx_ack(tx_ack), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_error(rx_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int nv = 0, ne = 0, na = 0, nb = 0, nm = 0, nboth = 0;
  logic [W-1:0] rxq[$];
  logic [W-1:0] exp_rx;

  // Cycle-level event counters; counting high cycles also catches stretched pulses.
  always @(negedge clk) begin
    if (rx_valid) begin nv++; rxq.push_back(rx_data); end
    if (rx_error) ne++;
    if (tx_ack) na++;
    if (busy) nb++;
    if (miso) nm++;
    if (rx_valid && rx_error) nboth++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, inout logic [31:0] mw);
    mosi = b;
    repeat (8) @(negedge clk);
    sclk = 1'b1;
    mw = {mw[30:0], miso};
    repeat (8) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [31:0] word, input int n, input int gap,
                       output logic [31:0] mw);
    mw = '0;
    sen = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) send_bit(word[i], mw);
    repeat (8) @(negedge clk);
    sen = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Bits the master should see on miso: tx word MSB first, zeros past WIDTH.
  function automatic logic [31:0] exp_miso(input logic [W-1:0] tx, input int n);
    logic [31:0] t;
    t = {8'h0, tx};
    return (n <= W) ? (t >> (W - n)) : (t << (n - W));
  endfunction

  task automatic std_frame(input logic [W-1:0] tx, input logic [31:0] word, input int n);
    int v0, e0, a0;
    logic [31:0] mw, mask;
    v0 = nv; e0 = ne; a0 = na;
    rxq.delete();
    tx_data = tx;
    frame(word, n, 12, mw);
    mask = 32'((64'd1 << n) - 1);
    chk("tx_ack_cnt", 32'(na - a0), 1);
    chk("miso_word", mw & mask, exp_miso(tx, n) & mask);
    if (n == W) begin
      exp_rx = word[W-1:0];
      chk("rx_valid_cnt", 32'(nv - v0), 1);
      chk("rx_error_cnt", 32'(ne - e0), 0);
      if (rxq.size() > 0) chk("rx_data_at_valid", {8'h0, rxq[0]}, {8'h0, exp_rx});
    end else begin
      chk("rx_valid_cnt", 32'(nv - v0), 0);
      chk("rx_error_cnt", 32'(ne - e0), 1);
    end
    chk("rx_data_hold", {8'h0, rx_data}, {8'h0, exp_rx});
    chk("busy_after", {31'h0, busy}, 0);
  endtask

  initial begin
    logic [31:0] mw1, mw2, mw;
    int v0, e0, a0, b0, m0, n;
    logic [W-1:0] tx;
    logic [31:0] word;

    exp_rx = '0;
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'h0, miso}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_pulses", {29'h0, tx_ack, rx_valid, rx_error}, 0);
    chk("rst_rx_data", {8'h0, rx_data}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    std_frame(24'hA5C3F0, 32'h123456, 24);   // single frame
    std_frame(24'h5A5A5A, 32'h0ABCDE, 20);   // short frame
    std_frame(24'h3C3C3C, 32'h2AAAAAA, 26);  // long frame
    std_frame(24'h0F0F0F, 32'hFFFFFF, 24);   // correct frame after overflow

    // Back-to-back frames separated by 4 cycles of sen high
    v0 = nv; a0 = na; rxq.delete();
    tx_data = 24'h000001;
    frame(32'hC0FFEE, 24, 4, mw1);
    tx_data = 24'h800000;
    frame(32'h135799, 24, 12, mw2);
    chk("b2b_valid_cnt", 32'(nv - v0), 2);
    chk("b2b_ack_cnt", 32'(na - a0), 2);
    chk("b2b_miso1", mw1, 32'h000001);
    chk("b2b_miso2", mw2, 32'h800000);
    chk("b2b_q_size", 32'(rxq.size()), 2);
    if (rxq.size() == 2) begin
      chk("b2b_rx1", {8'h0, rxq[0]}, 32'hC0FFEE);
      chk("b2b_rx2", {8'h0, rxq[1]}, 32'h135799);
    end
    exp_rx = 24'h135799;

    // Reset mid-frame: the remainder of the frame must be ignored
    tx_data = 24'hFEDCBA;
    mw = '0;
    sen = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 23; i >= 14; i--) send_bit(1'b1, mw);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_busy", {31'h0, busy}, 0);
    chk("midrst_rx_data", {8'h0, rx_data}, 0);
    rst = 1'b0;
    exp_rx = '0;
    v0 = nv; e0 = ne; a0 = na; b0 = nb;
    for (int i = 13; i >= 0; i--) send_bit(1'b0, mw);
    repeat (8) @(negedge clk);
    sen = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_valid", 32'(nv - v0), 0);
    chk("midrst_error", 32'(ne - e0), 0);
    chk("midrst_ack", 32'(na - a0), 0);
    chk("midrst_busy_cyc", 32'(nb - b0), 0);
    std_frame(24'h6B6B6B, 32'h2468AC, 24);

    // Idle noise with sen high
    v0 = nv; e0 = ne; a0 = na; b0 = nb; m0 = nm;
    for (int i = 0; i < 50; i++) begin
      sclk = ~sclk;
      mosi = 1'($urandom);
      repeat (5) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (10) @(negedge clk);
    chk("noise_pulses", 32'((nv - v0) + (ne - e0) + (na - a0)), 0);
    chk("noise_busy_cyc", 32'(nb - b0), 0);
    chk("noise_miso_cyc", 32'(nm - m0), 0);
    chk("noise_rx_data", {8'h0, rx_data}, {8'h0, exp_rx});

    // Randomized frames against the word-level model
    for (int k = 0; k < 12; k++) begin
      int r;
      tx   = W'($urandom);
      word = $urandom & 32'h03FF_FFFF;
      r    = $urandom_range(0, 5);
      n    = (r < 3) ? 24 : (r == 3) ? $urandom_range(20, 23) : $urandom_range(25, 26);
      std_frame(tx, word, n);
    end

    chk("never_both", 32'(nboth), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
